// File: rtl/conv_cmd_sequencer.sv
// Command sequencer between the conv APB register block and the conv core:
// streams input/bias/weight words into the buffers, launches the core and keeps the done status.
// Optional macro CONV_SEQ_CYCLE_CNT_EN enables the RUN-state cycle counter (clk_counter tied to 0 otherwise).
module conv_cmd_sequencer #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 32
) (
   input  logic              PCLK,
   input  logic              PRESETB,
   input  logic [2:0]        command,
   input  logic [5:0]        flen,
   input  logic [8:0]        in_ch,
   input  logic [8:0]        out_ch,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              mem_we,
   output logic [1:0]        mem_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              conv_start,
   input  logic              core_done,
   output logic              input_done,
   output logic              bias_done,
   output logic              weight_done,
   output logic              conv_done,
   output logic [31:0]       clk_counter
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      DONE_SET  = 3'd2,
      RUN_START = 3'd3,
      RUN_WAIT  = 3'd4
   } state_t;

   localparam logic [2:0] CMD_CLEAR       = 3'd0;
   localparam logic [2:0] CMD_LOAD_INPUT  = 3'd1;
   localparam logic [2:0] CMD_LOAD_BIAS   = 3'd2;
   localparam logic [2:0] CMD_LOAD_WEIGHT = 3'd3;
   localparam logic [2:0] CMD_RUN         = 3'd4;

   localparam logic [1:0] SEL_INPUT  = 2'd0;
   localparam logic [1:0] SEL_BIAS   = 2'd1;
   localparam logic [1:0] SEL_WEIGHT = 2'd2;

   state_t              state_q, state_d;
   logic [2:0]          last_cmd_q, last_cmd_d;
   logic [ADDR_W-1:0]   count_q, count_d;
   logic [ADDR_W-1:0]   target_q, target_d;
   logic                mem_we_q, mem_we_d;
   logic [1:0]          mem_sel_q, mem_sel_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                input_done_q, input_done_d;
   logic                bias_done_q, bias_done_d;
   logic                weight_done_q, weight_done_d;
   logic                conv_done_q, conv_done_d;

   logic [ADDR_W-1:0]   flen_w, in_ch_w, out_ch_w;
   logic [ADDR_W-1:0]   input_words, bias_words, weight_words;
   logic [ADDR_W-1:0]   load_target;
   logic [1:0]          load_sel;
   logic                is_load_cmd;

   // Word counts are 4 bytes per word, rounded up; ADDR_W is wide enough for the largest shapes.
   assign flen_w       = ADDR_W'(flen);
   assign in_ch_w      = ADDR_W'(in_ch);
   assign out_ch_w     = ADDR_W'(out_ch);
   assign input_words  = (flen_w * flen_w * in_ch_w + ADDR_W'(3)) >> 2;
   assign bias_words   = out_ch_w;
   assign weight_words = (out_ch_w * in_ch_w * ADDR_W'(9) + ADDR_W'(3)) >> 2;

   always_comb begin
      load_target = '0;
      load_sel    = SEL_INPUT;
      is_load_cmd = 1'b0;
      case (command)
         CMD_LOAD_INPUT: begin
            load_target = input_words;
            load_sel    = SEL_INPUT;
            is_load_cmd = 1'b1;
         end
         CMD_LOAD_BIAS: begin
            load_target = bias_words;
            load_sel    = SEL_BIAS;
            is_load_cmd = 1'b1;
         end
         CMD_LOAD_WEIGHT: begin
            load_target = weight_words;
            load_sel    = SEL_WEIGHT;
            is_load_cmd = 1'b1;
         end
         default: ;
      endcase
   end

   assign s_ready    = (state_q == LOAD);
   assign conv_start = (state_q == RUN_START);

   always_comb begin
      state_d       = state_q;
      last_cmd_d    = last_cmd_q;
      count_d       = count_q;
      target_d      = target_q;
      mem_we_d      = 1'b0;
      mem_sel_d     = mem_sel_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      input_done_d  = input_done_q;
      bias_done_d   = bias_done_q;
      weight_done_d = weight_done_q;
      conv_done_d   = conv_done_q;

      case (state_q)
         IDLE: begin
            if (command != last_cmd_q) begin
               last_cmd_d = command;
               if (command == CMD_CLEAR) begin
                  input_done_d  = 1'b0;
                  bias_done_d   = 1'b0;
                  weight_done_d = 1'b0;
                  conv_done_d   = 1'b0;
               end else if (command == CMD_RUN) begin
                  state_d = RUN_START;
               end else if (is_load_cmd) begin
                  mem_sel_d = load_sel;
                  target_d  = load_target;
                  count_d   = '0;
                  state_d   = (load_target == '0) ? DONE_SET : LOAD;
               end
            end
         end
         LOAD: begin
            if (s_valid && s_ready) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = count_q;
               mem_wdata_d = s_data;
               count_d     = count_q + ADDR_W'(1);
               if (count_q == target_q - ADDR_W'(1)) begin
                  state_d = DONE_SET;
               end
            end
         end
         DONE_SET: begin
            case (mem_sel_q)
               SEL_INPUT:  input_done_d  = 1'b1;
               SEL_BIAS:   bias_done_d   = 1'b1;
               SEL_WEIGHT: weight_done_d = 1'b1;
               default: ;
            endcase
            state_d = IDLE;
         end
         RUN_START: begin
            conv_done_d = 1'b0;
            state_d     = RUN_WAIT;
         end
         RUN_WAIT: begin
            if (core_done) begin
               conv_done_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETB) begin
         state_q       <= IDLE;
         last_cmd_q    <= 3'd0;
         count_q       <= '0;
         target_q      <= '0;
         mem_we_q      <= 1'b0;
         mem_sel_q     <= 2'd0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         input_done_q  <= 1'b0;
         bias_done_q   <= 1'b0;
         weight_done_q <= 1'b0;
         conv_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_cmd_q    <= last_cmd_d;
         count_q       <= count_d;
         target_q      <= target_d;
         mem_we_q      <= mem_we_d;
         mem_sel_q     <= mem_sel_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         input_done_q  <= input_done_d;
         bias_done_q   <= bias_done_d;
         weight_done_q <= weight_done_d;
         conv_done_q   <= conv_done_d;
      end
   end

   assign mem_we      = mem_we_q;
   assign mem_sel     = mem_sel_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign input_done  = input_done_q;
   assign bias_done   = bias_done_q;
   assign weight_done = weight_done_q;
   assign conv_done   = conv_done_q;

`ifdef CONV_SEQ_CYCLE_CNT_EN
   logic [31:0] clk_cnt_q, clk_cnt_d;

   // Counts every RUN_WAIT cycle including the one carrying core_done, then holds until the next run.
   always_comb begin
      clk_cnt_d = clk_cnt_q;
      if (state_q == RUN_START) begin
         clk_cnt_d = 32'd0;
      end else if (state_q == RUN_WAIT) begin
         clk_cnt_d = clk_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETB) begin
         clk_cnt_q <= 32'd0;
      end else begin
         clk_cnt_q <= clk_cnt_d;
      end
   end

   assign clk_counter = clk_cnt_q;
`else
   assign clk_counter = 32'h0;
`endif

endmodule

// File: doc/conv_cmd_sequencer.md
Name: conv_cmd_sequencer

Overview:
- Sits directly downstream of the conv APB register block.
- Consumes the software-written command, flen, in_ch and out_ch.
- Sequences buffer loads (input feature map, bias, weight) from a 32-bit data stream into the conv buffers, then launches the conv core.
- Produces the input_done, bias_done, weight_done and conv_done status bits and the clk_counter value that the register block reads back.

Parameters:
- ADDR_W, 23, width of buffer write address and of the internal word counters.
- DATA_W, 32, stream and buffer write data width.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETB  in  1  synchronous active-low reset, sampled on rising PCLK.
- command  in  3  0=CLEAR, 1=LOAD_INPUT, 2=LOAD_BIAS, 3=LOAD_WEIGHT, 4=RUN; 5-7 reserved.
- flen  in  6  feature-map side length.
- in_ch  in  9  input channel count.
- out_ch  in  9  output channel count.
- s_valid  in  1  stream word valid.
- s_data  in  DATA_W  stream word.
- s_ready  out  1  stream ready.
- mem_we  out  1  buffer write strobe.
- mem_sel  out  2  target buffer: 0=input, 1=bias, 2=weight.
- mem_addr  out  ADDR_W  word address, starting at 0 for each load.
- mem_wdata  out  DATA_W  registered copy of s_data.
- conv_start  out  1  one-cycle pulse to the conv core.
- core_done  in  1  conv core completion pulse.
- input_done  out  1  sticky status bit.
- bias_done  out  1  sticky status bit.
- weight_done  out  1  sticky status bit.
- conv_done  out  1  sticky status bit.
- clk_counter  out  32  RUN-state cycle count.

Behaviour:
- Reset: PRESETB=0 at a PCLK edge forces state IDLE and clears every output and counter to 0: s_ready, mem_we, mem_sel, mem_addr, mem_wdata, conv_start, all four done bits, clk_counter. Internal last_cmd=0. A reset mid-load or mid-run aborts the operation without a further mem_we or conv_start.
- Command acceptance: a command is accepted only in IDLE, on a cycle where command != last_cmd. On acceptance, last_cmd<=command. A command changed while not in IDLE is ignored until return to IDLE, then evaluated normally.
- CLEAR (0): accepted in IDLE; clears all four done bits the next cycle; state stays IDLE.
- Reserved commands (5-7): update last_cmd only; no other effect.
- Word targets are latched at acceptance:
  - Input: ceil(flen*flen*in_ch/4).
  - Bias: out_ch.
  - Weight: ceil(out_ch*in_ch*9/4).
  - All arithmetic is unsigned and ADDR_W wide, so there is no overflow at maximum values.
- Zero-target load: a target of 0 goes straight to DONE_SET with no writes.
- States:
  - IDLE: idle; accepts commands.
  - LOAD: s_ready=1. Each s_valid&s_ready cycle registers mem_we=1, mem_addr=count, mem_wdata=s_data the next cycle, then count++. The cycle that consumes word target-1 drops s_ready the next cycle; no further words are accepted. Go to DONE_SET.
  - DONE_SET: sets the matching done bit (input/bias/weight); returns to IDLE after 1 cycle.
  - RUN_START: conv_start=1 for exactly one cycle; clears conv_done and clk_counter; go to RUN_WAIT.
  - RUN_WAIT: clk_counter increments each cycle; on core_done=1, set conv_done and go to IDLE. A core_done in any other state is ignored.
- Latency:
  - Command change to first s_ready: 1 cycle.
  - Accepted word to mem_we: 1 cycle.
  - Last word to done bit visible: 2 cycles.
- Done bit lifetime: done bits stay set until CLEAR or reset. Re-issuing the same load requires writing a different command (e.g. CLEAR) first.
- Bubbles: s_valid=0 cycles insert no writes and do not advance the counter.
- Simultaneous events: a core_done coinciding with a command change is processed as core_done; the command is evaluated in the following IDLE cycle.

Optional Feature:
- Macro: CONV_SEQ_CYCLE_CNT_EN.
- Defined: clk_counter behaves as above; it holds its value after RUN completes until the next RUN_START.
- Undefined: the counter logic is absent and clk_counter is tied to 32'h0.

Test Plan:
- flen=4, in_ch=3, command 0->1, 12 words streamed back-to-back -> mem_addr 0..11 with mem_sel=0; s_ready low after the 12th word; input_done=1 two cycles after the last word; a 13th s_valid is not accepted.
- out_ch=5, command 2, s_valid toggled every other cycle -> exactly 5 writes to addresses 0..4 with mem_sel=1; bias_done=1; no write on bubble cycles.
- in_ch=1, out_ch=2, command 3 -> target ceil(18/4)=5 words with mem_sel=2; weight_done=1.
- command 4, core_done asserted 100 cycles after conv_start -> exactly one conv_start pulse; conv_done=1; with CONV_SEQ_CYCLE_CNT_EN, clk_counter=100; without it, clk_counter=0.
- PRESETB low for 1 cycle during LOAD after 3 words -> all outputs 0 the next cycle; a subsequent command 1 restarts at mem_addr 0.
- All done bits set, then command 0 -> all four clear one cycle later; flen=0 with command 1 -> input_done=1 with no mem_we.
